// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-request arbiter: FSM states, arbitration modes, op kinds.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority picker: first pending channel at or after start, wrapping.
// Zero latency; no flow control of its own (pure function of its inputs).
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     pending,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  int c;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    c         = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(start) + k) % N;
      if (!grant_vld && pending[c]) begin
        grant_vld   = 1'b1;
        grant_oh[c] = 1'b1;
        grant_idx   = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel memory-request arbiter onto one RAM port; min latency request->ready is 2 cycles.
// RAM busy stretches ACCESS (bounded by TIMEOUT abort); losing requesters simply wait.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 255
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_CH-1:0]        req_ren,
  input  logic [NUM_CH-1:0]        req_wen,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_store,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [NUM_CH-1:0]        req_err,
  output logic [DATA_W-1:0]        req_load,
  output logic                     Ren,
  output logic                     Wen,
  output logic [ADDR_W-1:0]        ramaddr,
  output logic [DATA_W-1:0]        ramstore,
  input  logic [DATA_W-1:0]        ramload,
  input  logic                     busy_o
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t              state;
  op_t                 sel_op;
  logic [NUM_CH-1:0]   pending;
  logic [NUM_CH-1:0]   pick_oh;
  logic [NUM_CH-1:0]   grant_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    grant;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    start;
  logic                pick_vld;
  logic [CNT_W-1:0]    tcnt;

  assign pending = req_ren | req_wen;
  assign start   = (RR_MODE == ARB_RR) ? rr_ptr : '0;

  rr_picker #(.N(NUM_CH), .IDX_W(IDX_W)) u_pick (
    .pending   (pending),
    .start     (start),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx),
    .grant_vld (pick_vld)
  );

  // A write request wins over a simultaneous read on the same channel.
  always_comb begin
    sel_op = req_wen[pick_idx] ? OP_WRITE : OP_READ;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      grant     <= '0;
      grant_oh  <= '0;
      rr_ptr    <= '0;
      tcnt      <= '0;
      Ren       <= 1'b0;
      Wen       <= 1'b0;
      ramaddr   <= '0;
      ramstore  <= '0;
      req_ready <= '0;
      req_err   <= '0;
      req_load  <= '0;
    end else begin
      req_ready <= '0;
      req_err   <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant    <= pick_idx;
            grant_oh <= pick_oh;
            ramaddr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            ramstore <= req_store[pick_idx*DATA_W +: DATA_W];
            Ren      <= (sel_op == OP_READ);
            Wen      <= (sel_op == OP_WRITE);
            tcnt     <= '0;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (!busy_o) begin
            if (Ren) req_load <= ramload;
            Ren       <= 1'b0;
            Wen       <= 1'b0;
            req_ready <= grant_oh;
            state     <= DONE;
          end else if (TIMEOUT != 0 && tcnt == CNT_W'(TIMEOUT)) begin
            Ren       <= 1'b0;
            Wen       <= 1'b0;
            req_ready <= grant_oh;
            req_err   <= grant_oh;
            state     <= DONE;
          end else if (tcnt != '1) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE: begin
          tcnt   <= '0;
          rr_ptr <= (grant == IDX_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised memory-request arbiter: the next-generation replacement for the fixed two-port instruction/data request path. It accepts read/write requests from NUM_CH independent requesters (fetch, data, future DMA/debug), selects one per transaction by fixed-priority or round-robin policy, and drives a single RAM port. It also handles the RAM busy handshake, returns load data with a one-cycle ready pulse, and aborts accesses that exceed a timeout.

## Interface
Parameters:
- NUM_CH, 2, number of requester channels (2..8); channel 0 is highest priority in fixed mode.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RR_MODE, 0, 0 = fixed priority, 1 = round robin.
- TIMEOUT, 255, maximum busy cycles per access before abort; 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- req_ren  in  NUM_CH  per-channel read request; level, held until ready.
- req_wen  in  NUM_CH  per-channel write request; level, held until ready.
- req_addr  in  NUM_CH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- req_store  in  NUM_CH*DATA_W  per-channel write data, packed the same way.
- req_ready  out  NUM_CH  one-hot, one-cycle completion pulse to the granted channel.
- req_err  out  NUM_CH  one-hot, one-cycle timeout-abort pulse; coincides with req_ready.
- req_load  out  DATA_W  shared read data; valid in the cycle req_ready is high; held until the next read completes.
- Ren  out  1  RAM read enable.
- Wen  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data; valid when busy_o is low.
- busy_o  in  1  RAM busy; the access completes in the first ACCESS cycle with busy_o low.

## Operation
- FSM states: IDLE, ACCESS, DONE (encoding defined in the package).
- IDLE:
  - A channel is pending when req_ren|req_wen is high.
  - When any channel is pending, the arbiter picks a winner and latches grant index, address, store data and op (write if req_wen, else read; wen wins if both are high).
  - It then moves to ACCESS. If nothing is pending, it stays in IDLE.
- Arbitration:
  - Fixed mode: lowest pending index wins.
  - RR mode: the search starts at pointer rr_ptr and wraps modulo NUM_CH. rr_ptr <= grant+1 (wrapping) on each completion. rr_ptr resets to 0.
- ACCESS:
  - Ren/Wen follow the latched op; ramaddr/ramstore come from the latches. All are stable for the whole state.
  - busy_o low: capture ramload into req_load (reads only), then go to DONE.
  - busy_o high: increment the timeout counter. If the count reaches TIMEOUT (and TIMEOUT != 0), set the abort flag and go to DONE; req_load is unchanged.
- DONE:
  - Ren=Wen=0. req_ready[grant]=1, and req_err[grant]=abort flag.
  - Always returns to IDLE next cycle. The timeout counter and abort flag clear.
- Changes to a requester's inputs after grant are ignored; latched values are used.
- A request dropped mid-access still completes and still pulses ready.
- Non-granted requests wait. No request is lost or reordered within a channel.
- Requesters must deassert in the cycle after seeing ready, otherwise they are re-granted as a new transaction.

## Timing
- Reset values: state IDLE, Ren=Wen=0, ramaddr=ramstore=0, req_ready=req_err=0, req_load=0, rr_ptr=0, timeout counter 0.
- Reset is asynchronous; asserting RST mid-ACCESS drops Ren/Wen immediately and the transaction is discarded with no ready pulse.
- Minimum latency: request seen in IDLE (cycle 0) -> ACCESS (cycle 1, busy_o low) -> req_ready (cycle 2).
- Each busy cycle adds one cycle. Back-to-back throughput is one transaction per 3 cycles minimum.
- Timeout: with busy_o stuck high, ACCESS lasts TIMEOUT+1 cycles (the abort is taken on the cycle the count reaches TIMEOUT), then DONE.
- Timeout counter width: clog2(TIMEOUT+1), minimum 1. It saturates and does not wrap.
- Ren and Wen are never high together. Both are 0 outside ACCESS.
- Simultaneous new request and DONE: the new request is evaluated in the following IDLE cycle; the pointer update is already applied.

## Structure
- Package mem_arb_pkg: state enum (IDLE, ACCESS, DONE), mode constants ARB_FIXED=0 / ARB_RR=1, op enum (OP_READ, OP_WRITE).
- Sub-module rr_picker: combinational pending-vector + start-pointer -> one-hot grant and index. Fixed mode is start pointer tied to 0.
- Top mem_arbiter holds the FSM, latches, timeout counter and rr_ptr.

## Test plan
- Single read, ch0, addr 0x100, busy_o low -> Ren high cycle 1 with ramaddr 0x100; req_ready[0] cycle 2; req_load = ramload value 0xDEADBEEF.
- Fixed mode, ch0 and ch1 both requesting continuously -> ch0 is granted every transaction and ch1 is starved. Then drop ch0 -> ch1 is granted in the next IDLE.
- RR mode, NUM_CH=4, all channels requesting writes -> grant order 0,1,2,3,0. Each ramstore matches its channel's req_store.
- busy_o high for 5 cycles on a write -> Wen held 6 cycles with addr/data stable; req_ready on the following cycle; no req_err.
- TIMEOUT=8, busy_o stuck high -> Ren held 9 cycles; req_ready and req_err pulse together; req_load retains its previous value.
- RST asserted during ACCESS -> Ren/Wen drop asynchronously, no ready pulse; after release a pending request restarts from IDLE with rr_ptr=0.
